// File: rtl/aes_round_pkg.sv
// Shared types and constants for the AES round sequencer.
package aes_round_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } aes_fsm_e;

  localparam int unsigned NR_AES128 = 10;
  localparam int unsigned NR_AES256 = 14;

  typedef logic [127:0] aes_state_t;

endpackage

// File: rtl/aes_round_seq.sv
// Round sequencer for an iterative AES core: owns the state register and round counter.
// Define AES_KEY256_EN to add the key256 input (NR=14 when set at accept, else 10).
module aes_round_seq
  import aes_round_pkg::*;
(
`ifdef AES_KEY256_EN
  input  logic         key256,
`endif
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  aes_state_t   mux_out,
  output logic         sel,
  output aes_state_t   state,
  output logic [3:0]   round,
  output logic         last_round,
  output logic         out_valid,
  input  logic         out_ready,
  output aes_state_t   ct
);

  localparam logic [3:0] NR128 = 4'(NR_AES128);

  aes_fsm_e   fsm_q, fsm_d;
  aes_state_t state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [3:0] nr;

`ifdef AES_KEY256_EN
  localparam logic [3:0] NR256 = 4'(NR_AES256);
  logic nr14_q, nr14_d;

  // Key length is latched at accept so a mid-block change of key256 has no effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nr14_q <= 1'b0;
    end else begin
      nr14_q <= nr14_d;
    end
  end

  assign nr = nr14_q ? NR256 : NR128;
`else
  assign nr = NR128;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      round_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    fsm_d      = fsm_q;
    state_d    = state_q;
    round_d    = round_q;
`ifdef AES_KEY256_EN
    nr14_d     = nr14_q;
`endif
    in_ready   = 1'b0;
    sel        = 1'b0;
    out_valid  = 1'b0;
    last_round = 1'b0;

    unique case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = mux_out;
          round_d = 4'd1;
          fsm_d   = RUN;
`ifdef AES_KEY256_EN
          nr14_d  = key256;
`endif
        end
      end
      RUN: begin
        sel        = 1'b1;
        last_round = (round_q == nr);
        state_d    = mux_out;
        if (round_q == nr) begin
          fsm_d = DONE;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      DONE: begin
        sel       = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          fsm_d   = IDLE;
          round_d = '0;
        end
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  assign state = state_q;
  assign ct    = state_q;
  assign round = round_q;

endmodule

// File: tb/tb_aes_round_seq.sv
// Randomised bench: supplies the external selector/round datapath and checks against an AES-128 model.
module tb_aes_round_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] mux_out;
  logic         sel;
  logic [127:0] state;
  logic [3:0]   round;
  logic         last_round;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ct;
`ifdef AES_KEY256_EN
  logic         key256;
`endif

  int     n_tests = 0;
  int     n_fail  = 0;
  longint cyc     = 0;

  logic [7:0]   sbox [256];
  logic [127:0] rk   [15];
  logic [127:0] cur_pt;
  logic [127:0] cur_key;
  logic [127:0] rnd_t;

  aes_round_seq dut (
`ifdef AES_KEY256_EN
    .key256     (key256),
`endif
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mux_out    (mux_out),
    .sel        (sel),
    .state      (state),
    .round      (round),
    .last_round (last_round),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ct         (ct)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = sbox[s[127-8*(r+4*((c+r)%4)) -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {gmul(a0,2) ^ gmul(a1,3) ^ a2 ^ a3,
                           a0 ^ gmul(a1,2) ^ gmul(a2,3) ^ a3,
                           a0 ^ a1 ^ gmul(a2,2) ^ gmul(a3,3),
                           gmul(a0,3) ^ a1 ^ a2 ^ gmul(a3,2)};
    end
    return o;
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] aes128_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] s;
    s = pt ^ key;
    for (int r = 1; r <= 10; r++) begin
      s = sub_shift(s);
      if (r != 10) s = mix(s);
      s = s ^ round_key(key, r);
    end
    return s;
  endfunction

  // External selector plus one AES round, driven from the DUT's sel/state/round/last_round.
  always_comb begin
    rnd_t = sub_shift(state);
    if (!last_round) rnd_t = mix(rnd_t);
    rnd_t = rnd_t ^ rk[round];
    mux_out = sel ? rnd_t : (cur_pt ^ cur_key);
  end

  task automatic run_block(input logic [127:0] pt, input logic [127:0] key, input int nr,
                           input int hold, input bit keep_valid,
                           output longint acc_cyc, output logic [127:0] ct_seen);
    int lat, lr_cnt;
    logic [127:0] ct0;
    cur_pt  = pt;
    cur_key = key;
    for (int r = 0; r < 15; r++) rk[r] = round_key(key, (r > 10) ? 10 : r);
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    check_eq("ready_before_accept", in_ready, 1);
    check_eq("sel_on_accept", sel, 0);
    in_valid = 1'b1;
    acc_cyc  = cyc + 1;
    lat = 0; lr_cnt = 0;
    for (int n = 1; n <= nr + 6; n++) begin
      @(negedge clk);
      if (!keep_valid) in_valid = 1'b0;
      check_eq("ready_valid_excl", in_ready & out_valid, 0);
      if (out_valid) begin
        lat = n;
        break;
      end
      check_eq("round_seq", round, n);
      check_eq("sel_run", sel, 1);
      check_eq("last_round", last_round, (n == nr));
      if (last_round) lr_cnt++;
    end
    check_eq("latency", lat, nr + 1);
    check_eq("last_round_once", lr_cnt, 1);
    ct0 = ct;
    ct_seen = ct;
    if (nr == 10) check_eq("ct_model", ct, aes128_ref(pt, key));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("ct_hold", ct, ct0);
      check_eq("out_valid_hold", out_valid, 1);
      check_eq("round_hold", round, nr);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("ready_after_done", in_ready, 1);
    check_eq("out_valid_cleared", out_valid, 0);
    check_eq("round_cleared", round, 0);
  endtask

  initial begin
    longint a0, a1, a2;
    logic [127:0] got_ct;
    logic [127:0] pt, key;
    bit ov_seen;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cur_pt = '0; cur_key = '0;
`ifdef AES_KEY256_EN
    key256 = 1'b0;
`endif
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, b;
      inv = '0;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbox[x] = b ^ rotl8(b,1) ^ rotl8(b,2) ^ rotl8(b,3) ^ rotl8(b,4) ^ 8'h63;
    end
    for (int r = 0; r < 15; r++) rk[r] = '0;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_sel", sel, 0);
    check_eq("rst_round", round, 0);
    check_eq("rst_state", state, 0);
    check_eq("rst_last_round", last_round, 0);

    // FIPS-197 vector with a 5-cycle consumer stall
    run_block(128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
              10, 5, 1'b0, a0, got_ct);
    check_eq("fips_ct", got_ct, 128'h3925841d02dc09fbdc118597196a0b32);

    // in_valid held high throughout: back-to-back blocks only from IDLE, one per NR+2 cycles
    pt = {$urandom, $urandom, $urandom, $urandom}; key = {$urandom, $urandom, $urandom, $urandom};
    run_block(pt, key, 10, 0, 1'b1, a0, got_ct);
    pt = {$urandom, $urandom, $urandom, $urandom}; key = {$urandom, $urandom, $urandom, $urandom};
    run_block(pt, key, 10, 0, 1'b1, a1, got_ct);
    pt = {$urandom, $urandom, $urandom, $urandom}; key = {$urandom, $urandom, $urandom, $urandom};
    run_block(pt, key, 10, 0, 1'b0, a2, got_ct);
    check_eq("throughput_1", a1 - a0, 12);
    check_eq("throughput_2", a2 - a1, 12);

    // reset pulse in the middle of RUN
    cur_pt  = {$urandom, $urandom, $urandom, $urandom};
    cur_key = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 20 && round != 4'd6; i++) @(negedge clk);
    check_eq("reached_round6", round, 6);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_in_ready", in_ready, 1);
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_sel", sel, 0);
    check_eq("mid_rst_round", round, 0);
    check_eq("mid_rst_state", state, 0);
    check_eq("mid_rst_last_round", last_round, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ov_seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (out_valid) ov_seen = 1'b1;
    end
    check_eq("no_stale_out_valid", ov_seen, 0);
    pt = {$urandom, $urandom, $urandom, $urandom}; key = {$urandom, $urandom, $urandom, $urandom};
    run_block(pt, key, 10, 1, 1'b0, a0, got_ct);

    // random blocks with random consumer stalls
    for (int k = 0; k < 6; k++) begin
      pt  = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      run_block(pt, key, 10, int'($urandom_range(0, 3)), 1'b0, a0, got_ct);
    end

`ifdef AES_KEY256_EN
    key256 = 1'b1;
    pt = {$urandom, $urandom, $urandom, $urandom}; key = {$urandom, $urandom, $urandom, $urandom};
    run_block(pt, key, 14, 2, 1'b0, a0, got_ct);
    key256 = 1'b0;
    run_block(pt, key, 10, 0, 1'b0, a0, got_ct);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
